harris_scan_ctrl: RTL and testbench
===================================

Name: harris_scan_ctrl

Overview:
- Sequencer for the shared Harris score datapath. It walks a WIN x WIN window across an IMG_W x IMG_H gradient image, raster order, stride 1.
- For each window it requests the window from the gradient window buffer, waits for the score unit's registered R, and thresholds it.
- Corner hits are queued in a small output FIFO as (x, y, R) events with valid/ready handoff to the downstream non-max-suppression stage.

Parameters:
- IMG_W, 64, image width in pixels
- IMG_H, 64, image height in pixels
- WIN, 4, window edge; must equal the score unit window size
- SCORE_LAT, 1, cycles from window-valid to R-valid at the score unit (min 1)
- FIFO_DEPTH, 4, corner event FIFO entries (power of 2, >= 2)
- CW, $clog2(IMG_W > IMG_H ? IMG_W : IMG_H), coordinate width

Ports:
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, begin one frame scan; ignored unless idle
- abort, in, 1, terminate scan, flush FIFO, no done pulse
- thresh, in, 64, signed corner threshold; sampled on the accepted start
- win_load, out, 1, request the window whose top-left corner is (win_x, win_y)
- win_x, out, CW, window column
- win_y, out, CW, window row
- win_ack, in, 1, buffer accepts the request; Gx/Gy are stable from the next cycle until the next win_load
- score_R, in, 64, signed R from the score unit
- corner_valid, out, 1, FIFO head valid
- corner_ready, in, 1, downstream accepts the head
- corner_x, out, CW, head column
- corner_y, out, CW, head row
- corner_R, out, 64, head score
- busy, out, 1, high in every state except IDLE
- done, out, 1, one-cycle pulse when the frame has completed and drained
- corner_count, out, 16, corners found in the current/last frame; saturates at 16'hFFFF

Behaviour:
- Reset values: all outputs 0; state = IDLE; FIFO empty; counters 0. Reset mid-scan has the same effect as at power-up.
- IDLE: when start=1, latch thresh, clear win_x, win_y and corner_count, and go to LOAD.
- LOAD: win_load=1 with win_x/win_y held.
  - On win_ack=1, go to SCORE and load lat_cnt = SCORE_LAT.
  - win_load drops in the cycle after ack.
- SCORE: lat_cnt decrements each cycle; go to EVAL when it reaches 0 (SCORE_LAT cycles in SCORE).
- EVAL: sample score_R and compare it signed with the latched threshold. Hit = score_R > thresh (strict).
  - Hit with FIFO not full: push (win_x, win_y, score_R), increment corner_count, go to ADV.
  - Hit with FIFO full: stay in EVAL, sampling each cycle, until a pop frees an entry. A pop and a push in the same cycle are allowed when the FIFO is full.
  - Miss: go to ADV.
- ADV:
  - If win_x < IMG_W-WIN: win_x++.
  - Else: win_x=0 and win_y++.
  - If the window just evaluated was (IMG_W-WIN, IMG_H-WIN), go to DRAIN; otherwise go to LOAD.
- DRAIN: wait for the FIFO to empty, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. corner_count holds until the next start.
- Window count = (IMG_W-WIN+1)*(IMG_H-WIN+1).
- Per-window cost = 3 + SCORE_LAT cycles with immediate ack and no stall.
- abort in any non-IDLE state has priority over every other transition:
  - next cycle: IDLE, win_load=0, FIFO flushed (corner_valid=0), no done pulse.
  - corner_count keeps its value.
- start while busy is ignored. start and abort high together in IDLE: abort wins and the state stays IDLE.
- FIFO behaviour:
  - first-word-fall-through: the head is visible on corner_* whenever corner_valid=1.
  - pop when corner_valid & corner_ready.
  - corner_* hold stable while corner_valid=1 and corner_ready=0.
  - order preserved.
- Arithmetic: the compare is full 64-bit signed. Coordinates are unsigned CW bits and never exceed IMG_W-WIN / IMG_H-WIN.

Test Plan:
- IMG_W=IMG_H=5, WIN=4, SCORE_LAT=1, win_ack tied 1, thresh=100, score_R=50 for all windows, start -> win_load addresses (0,0),(1,0),(0,1),(1,1); no corner_valid; done pulses 4*4+1 cycles (incl. DONE) after LOAD entry; corner_count=0.
- Same params, score_R=200 only for window (1,0), corner_ready=1 -> exactly one event x=1, y=0, R=200; corner_count=1; done after the FIFO drains.
- Threshold boundary and sign: thresh=-10, score_R=-10 -> no hit; score_R=-9 -> hit. thresh=100, score_R=100 -> no hit.
- FIFO backpressure: FIFO_DEPTH=2, all windows hit, corner_ready=0 -> controller stalls in EVAL on the 3rd window with win_load low. Raise corner_ready -> events (0,0),(1,0),(0,1),(1,1) emerge in order, corner_* stable while stalled, done only after the last pop.
- win_ack delayed 3 cycles per window -> win_load and win_x/win_y held steady throughout; results identical to the first scenario.
- abort asserted in SCORE of window (1,0) with one event queued -> next cycle busy=0, corner_valid=0, no done. A following start rescans from (0,0) with corner_count cleared.

Source files
------------

// File: rtl/harris_scan_ctrl.sv
// Harris corner scan sequencer: walks windows, thresholds R,
// and queues corner events in a small FWFT FIFO.
module harris_scan_ctrl #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int WIN        = 4,
  parameter int SCORE_LAT  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CW = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [63:0]   thresh_i,
  output logic          win_load_o,
  output logic [CW-1:0] win_x_o,
  output logic [CW-1:0] win_y_o,
  input  logic          win_ack_i,
  input  logic [63:0]   score_R_i,
  output logic          corner_valid_o,
  input  logic          corner_ready_i,
  output logic [CW-1:0] corner_x_o,
  output logic [CW-1:0] corner_y_o,
  output logic [63:0]   corner_R_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [15:0]   corner_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(SCORE_LAT + 1);
  localparam logic [CW-1:0] XMAX = CW'(IMG_W - WIN);
  localparam logic [CW-1:0] YMAX = CW'(IMG_H - WIN);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SCORE, S_EVAL, S_ADV, S_DRAIN, S_DONE
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      x_q, y_q;
  logic signed [63:0] thr_q;
  logic [15:0]        cnt_q;
  logic [LW-1:0]      lat_q;
  logic               load_q, busy_q, done_q;

  logic [CW-1:0] fx_q [FIFO_DEPTH];
  logic [CW-1:0] fy_q [FIFO_DEPTH];
  logic [63:0]   fr_q [FIFO_DEPTH];
  logic [AW:0]   wp_q, rp_q, wp_d, rp_d;

  logic empty, full, pop, push, hit;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop   = !empty && corner_ready_i;
  assign hit   = $signed(score_R_i) > thr_q;
  // a pop frees the slot the same cycle, so a full FIFO can still take a push
  assign push  = (state_q == S_EVAL) && hit &&
                 (!full || pop) && !abort_i;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fx_q[wp_q[AW-1:0]] <= x_q;
      fy_q[wp_q[AW-1:0]] <= y_q;
      fr_q[wp_q[AW-1:0]] <= score_R_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      thr_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= S_IDLE;
        load_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: if (start_i) begin
            thr_q   <= $signed(thresh_i);
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
          S_LOAD: if (win_ack_i) begin
            lat_q   <= LW'(SCORE_LAT);
            load_q  <= 1'b0;
            state_q <= S_SCORE;
          end
          S_SCORE: begin
            lat_q <= lat_q - 1'b1;
            if (lat_q == LW'(1)) state_q <= S_EVAL;
          end
          S_EVAL: begin
            if (!hit) begin
              state_q <= S_ADV;
            end else if (push) begin
              if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
              state_q <= S_ADV;
            end
          end
          S_ADV: begin
            if (x_q == XMAX && y_q == YMAX) begin
              state_q <= S_DRAIN;
            end else begin
              if (x_q < XMAX) begin
                x_q <= x_q + 1'b1;
              end else begin
                x_q <= '0;
                y_q <= y_q + 1'b1;
              end
              load_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
          S_DRAIN: if (empty) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign win_load_o     = load_q;
  assign win_x_o        = x_q;
  assign win_y_o        = y_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign corner_count_o = cnt_q;
  assign corner_valid_o = !empty;
  assign corner_x_o = empty ? '0 : fx_q[rp_q[AW-1:0]];
  assign corner_y_o = empty ? '0 : fy_q[rp_q[AW-1:0]];
  assign corner_R_o = empty ? '0 : fr_q[rp_q[AW-1:0]];

endmodule

// File: tb/tb_harris_scan_ctrl.sv
// Directed bench for harris_scan_ctrl on a 5x5 image, 4x4 windows.
// Stimulus queues expected addresses/events; a monitor pops and checks.
module tb_harris_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, ack, ready;
  logic [63:0] thresh, score;
  logic        wl, cv, busy, done;
  logic [2:0]  wx, wy, cx, cy;
  logic [63:0] cr;
  logic [15:0] ccnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ack_dly = 0;
  int wl_cnt = 0;

  longint tbl [4];

  typedef struct {
    int     x;
    int     y;
    longint r;
  } ev_t;

  ev_t ev_q [$];
  int  ad_q [$];

  harris_scan_ctrl #(
    .IMG_W(5), .IMG_H(5), .WIN(4),
    .SCORE_LAT(1), .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .start_i(start), .abort_i(abort),
    .thresh_i(thresh),
    .win_load_o(wl), .win_x_o(wx), .win_y_o(wy),
    .win_ack_i(ack), .score_R_i(score),
    .corner_valid_o(cv), .corner_ready_i(ready),
    .corner_x_o(cx), .corner_y_o(cy), .corner_R_o(cr),
    .busy_o(busy), .done_o(done),
    .corner_count_o(ccnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // window buffer and score unit models
  assign ack   = wl && (wl_cnt >= ack_dly);
  assign score = tbl[{wy[0], wx[0]}];

  always @(posedge clk)
    wl_cnt <= (wl && !ack) ? wl_cnt + 1 : 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event want none", nm);
  endtask

  logic        wl_hold = 1'b0;
  logic        cv_hold = 1'b0;
  logic [2:0]  px, py, hx, hy;
  logic [63:0] hr;

  always @(negedge clk) begin
    if (!rst) begin
      if (wl && wl_hold) begin
        chk("load_x_hold", wx, px);
        chk("load_y_hold", wy, py);
      end
      if (wl && ack) begin
        if (ad_q.size() == 0) fail("load_unexpected");
        else begin
          int a;
          a = ad_q.pop_front();
          chk("load_addr", {wx, wy}, a);
        end
      end
      if (cv && cv_hold) begin
        chk("stall_x", cx, hx);
        chk("stall_y", cy, hy);
        chk("stall_r", cr, hr);
      end
      if (cv && ready) begin
        if (ev_q.size() == 0) fail("event_unexpected");
        else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("ev_x", cx, e.x);
          chk("ev_y", cy, e.y);
          chk("ev_r", cr, e.r);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_drained", ev_q.size(), 0);
      end
    end
    wl_hold = wl && !ack;
    px = wx; py = wy;
    cv_hold = cv && !ready;
    hx = cx; hy = cy; hr = cr;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_tbl(input longint a, input longint b,
                         input longint c, input longint d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
  endtask

  task automatic push_ev(input int x, input int y,
                         input longint r);
    ev_t e;
    e.x = x; e.y = y; e.r = r;
    ev_q.push_back(e);
  endtask

  task automatic start_scan(input longint th, output int t0);
    thresh = th;
    ad_q.push_back({3'd0, 3'd0});
    ad_q.push_back({3'd1, 3'd0});
    ad_q.push_back({3'd0, 3'd1});
    ad_q.push_back({3'd1, 3'd1});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, input int exp_lat,
                           input int exp_cnt);
    int got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
    end else begin
      if (exp_lat >= 0) chk("done_latency", cyc - t0, exp_lat);
      chk("corner_count", ccnt, exp_cnt);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
    end
    tick(1);
  endtask

  initial begin
    int t0;
    int seen;
    int dc;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    ready = 1'b0; thresh = '0;
    set_tbl(0, 0, 0, 0);
    tick(3);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_load", wl, 0);
    chk("rst_valid", cv, 0);
    chk("rst_done", done, 0);
    chk("rst_count", ccnt, 0);
    chk("rst_wx", wx, 0);
    rst = 1'b0;
    tick(2);

    // all misses
    set_tbl(50, 50, 50, 50);
    start_scan(100, t0);
    wait_done(t0, 17, 0);

    // one hit at window (1,0)
    ready = 1'b1;
    set_tbl(50, 200, 50, 50);
    push_ev(1, 0, 200);
    start_scan(100, t0);
    wait_done(t0, 17, 1);

    // threshold boundary and sign
    set_tbl(-10, -10, -10, -10);
    start_scan(-10, t0);
    wait_done(t0, 17, 0);
    set_tbl(-9, -9, -9, -9);
    push_ev(0, 0, -9); push_ev(1, 0, -9);
    push_ev(0, 1, -9); push_ev(1, 1, -9);
    start_scan(-10, t0);
    wait_done(t0, 17, 4);
    set_tbl(100, 100, 100, 100);
    start_scan(100, t0);
    wait_done(t0, 17, 0);

    // backpressure with a 2-entry FIFO
    ready = 1'b0;
    set_tbl(500, 501, 502, 503);
    push_ev(0, 0, 500); push_ev(1, 0, 501);
    push_ev(0, 1, 502); push_ev(1, 1, 503);
    start_scan(0, t0);
    tick(30);
    @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_load", wl, 0);
    chk("stall_valid", cv, 1);
    chk("stall_head_x", cx, 0);
    chk("stall_head_r", cr, 500);
    chk("stall_count", ccnt, 2);
    chk("stall_no_done", done_cnt, 5);
    tick(1);
    ready = 1'b1;
    wait_done(t0, -1, 4);

    // delayed acknowledge
    ack_dly = 3;
    set_tbl(50, 50, 50, 50);
    start_scan(100, t0);
    wait_done(t0, 29, 0);
    ack_dly = 0;

    // abort in SCORE of window (1,0)
    ready = 1'b0;
    set_tbl(300, 50, 50, 50);
    start_scan(100, t0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wl && ack && wx == 3'd1 && wy == 3'd0) begin
        seen = 1;
        break;
      end
    end
    chk("abort_reach", seen, 1);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", cv, 0);
    chk("abort_load", wl, 0);
    chk("abort_count", ccnt, 1);
    ad_q.delete();
    dc = done_cnt;
    tick(10);
    chk("abort_no_done", done_cnt, dc);

    // start and abort together stay idle
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy, 0);
    chk("start_abort_load", wl, 0);
    tick(1);

    // rescan from (0,0) with the count cleared
    ready = 1'b1;
    set_tbl(50, 50, 50, 50);
    start_scan(100, t0);
    @(negedge clk);
    chk("rescan_count_clr", ccnt, 0);
    chk("rescan_x", wx, 0);
    wait_done(t0, 17, 0);

    chk("addr_q_empty", ad_q.size(), 0);
    chk("ev_q_empty", ev_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
